// File: rtl/fpc_sched_if.sv
// Requester, shared-FPU and response signals of the fpc_sched arbiter.
interface fpc_sched_if;
    logic [1:0]  req_valid;
    logic [1:0]  req_mode;
    logic [15:0] req_a0;
    logic [15:0] req_b0;
    logic [15:0] req_a1;
    logic [15:0] req_b1;
    logic [1:0]  req_ready;
    logic        fpu_in_valid;
    logic        fpu_mode;
    logic [15:0] fpu_a;
    logic [15:0] fpu_b;
    logic        fpu_out_valid;
    logic [15:0] fpu_out;
    logic [1:0]  resp_valid;
    logic [15:0] resp_data;
    logic [1:0]  err;
    logic        busy;

    modport master (
        output req_valid, req_mode, req_a0, req_b0, req_a1, req_b1,
        output fpu_out_valid, fpu_out,
        input  req_ready, fpu_in_valid, fpu_mode, fpu_a, fpu_b,
        input  resp_valid, resp_data, err, busy
    );

    modport slave (
        input  req_valid, req_mode, req_a0, req_b0, req_a1, req_b1,
        input  fpu_out_valid, fpu_out,
        output req_ready, fpu_in_valid, fpu_mode, fpu_a, fpu_b,
        output resp_valid, resp_data, err, busy
    );
endinterface

// File: rtl/fpc_sched.sv
// Round-robin scheduler sharing one bfloat16 add/mul unit between two requesters,
// with a bounded wait for the unit's result and a per-requester timeout error.
module fpc_sched #(
    parameter int TIMEOUT = 4
) (
    input logic        clk,
    input logic        rst_n,
    fpc_sched_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    localparam logic [3:0] TO_CNT = 4'(TIMEOUT);

    state_t      state, state_nx;
    logic        last_grant;
    logic        cap_id;
    logic        cap_mode;
    logic [15:0] cap_a;
    logic [15:0] cap_b;
    logic [3:0]  cnt;
    logic [1:0]  resp_q;
    logic [1:0]  err_q;
    logic [15:0] resp_data_q;
    logic [1:0]  grant;
    logic        hs;
    logic        timeout;

    always_comb begin
        grant = '0;
        case (bus.req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = '0;
        endcase
    end

    assign hs      = rst_n && (state == IDLE) && (bus.req_valid != 2'b00);
    assign timeout = (state == WAIT) && (cnt == TO_CNT) && !bus.fpu_out_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (hs) state_nx = ISSUE;
            ISSUE:   state_nx = WAIT;
            WAIT:    if (bus.fpu_out_valid || cnt == TO_CNT) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs are gated by rst_n so they read 0 throughout the reset cycle itself.
    always_comb begin
        bus.req_ready    = '0;
        bus.fpu_in_valid = 1'b0;
        bus.fpu_mode     = 1'b0;
        bus.fpu_a        = '0;
        bus.fpu_b        = '0;
        bus.busy         = 1'b0;
        if (rst_n) begin
            case (state)
                IDLE: bus.req_ready = grant;
                ISSUE: begin
                    bus.fpu_in_valid = 1'b1;
                    bus.fpu_mode     = cap_mode;
                    bus.fpu_a        = cap_a;
                    bus.fpu_b        = cap_b;
                    bus.busy         = 1'b1;
                end
                WAIT:    bus.busy = 1'b1;
                default: bus.busy = 1'b0;
            endcase
        end
        bus.resp_valid = rst_n ? resp_q : '0;
        bus.err        = rst_n ? err_q  : '0;
        bus.resp_data  = resp_data_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant  <= 1'b1;
            cap_id      <= 1'b0;
            cap_mode    <= 1'b0;
            cap_a       <= '0;
            cap_b       <= '0;
            cnt         <= '0;
            resp_q      <= '0;
            err_q       <= '0;
            resp_data_q <= '0;
        end else begin
            resp_q <= '0;
            err_q  <= '0;
            if (hs) begin
                last_grant <= grant[1];
                cap_id     <= grant[1];
                cap_mode   <= bus.req_mode[grant[1]];
                cap_a      <= grant[1] ? bus.req_a1 : bus.req_a0;
                cap_b      <= grant[1] ? bus.req_b1 : bus.req_b0;
            end
            if (state_nx == WAIT) cnt <= (state == WAIT) ? cnt + 4'd1 : 4'd1;
            else                  cnt <= '0;
            // A result arriving on the timeout cycle wins over the error.
            if (state == WAIT && bus.fpu_out_valid) begin
                resp_data_q <= bus.fpu_out;
                resp_q      <= {cap_id, ~cap_id};
            end else if (timeout) begin
                err_q <= {cap_id, ~cap_id};
            end
        end
    end

endmodule

// File: tb/tb_fpc_sched.sv
// Bench for fpc_sched: stub bf16 unit, transaction-level expectation model, directed and random steps.
module tb_fpc_sched;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fpc_sched_if ifc();

    fpc_sched #(.TIMEOUT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    int checks = 0;
    int failures = 0;

    function automatic real bf2r(input logic [15:0] x);
        logic [63:0] d;
        if (x[14:0] == 15'd0) d = {x[15], 63'd0};
        else d = {x[15], 11'(x[14:7]) + 11'd896, x[6:0], 45'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [15:0] r2bf(input real r);
        logic [63:0] d;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return {d[63], 15'd0};
        return {d[63], 8'(d[62:52] - 11'd896), d[51:45]};
    endfunction

    function automatic logic [15:0] fpu_op(input logic mode, input logic [15:0] a, input logic [15:0] b);
        return mode ? r2bf(bf2r(a) * bf2r(b)) : r2bf(bf2r(a) + bf2r(b));
    endfunction

    function automatic logic [15:0] rnd_bf();
        logic [7:0] e;
        e = 8'(120 + $urandom_range(0, 14));
        return {1'($urandom), e, 7'($urandom)};
    endfunction

    // Stub shared unit: fixed two-cycle latency, or silent while stall is set.
    logic        s1 = 1'b0, s2 = 1'b0, stall = 1'b0, spur = 1'b0;
    logic [15:0] d1 = '0, d2 = '0, spur_data = '0;
    always @(posedge clk) begin
        s1 <= ifc.fpu_in_valid;
        d1 <= fpu_op(ifc.fpu_mode, ifc.fpu_a, ifc.fpu_b);
        s2 <= s1 & ~stall;
        d2 <= d1;
    end
    assign ifc.fpu_out_valid = s2 | spur;
    assign ifc.fpu_out       = spur ? spur_data : d2;

    // Expectation model in terms of transactions and cycle numbers.
    int          cyc = 0, free_at = 0, issue_at = -1, resp_at = -1, err_at = -1;
    logic        lg = 1'b1, cur_id = 1'b0, resp_id = 1'b0, err_id = 1'b0, iss_mode = 1'b0;
    logic [15:0] iss_a = '0, iss_b = '0, pend_data = '0, exp_data = '0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic [1:0] v, input logic [1:0] m,
                        input logic [15:0] a0, input logic [15:0] b0,
                        input logic [15:0] a1, input logic [15:0] b1,
                        input logic sp, input logic [15:0] spd);
        logic       idle, g, e_iv, e_busy;
        logic [1:0] e_ready, e_resp, e_err;
        rst_n = r; ifc.req_valid = v; ifc.req_mode = m;
        ifc.req_a0 = a0; ifc.req_b0 = b0; ifc.req_a1 = a1; ifc.req_b1 = b1;
        spur = sp; spur_data = spd;
        #1;
        if (cyc == resp_at) exp_data = pend_data;
        idle    = (cyc >= free_at);
        g       = (v == 2'b11) ? ~lg : v[1];
        e_ready = (r && idle && v != 2'b00) ? (g ? 2'b10 : 2'b01) : 2'b00;
        e_busy  = r && !idle;
        e_iv    = r && (cyc == issue_at);
        e_resp  = (r && cyc == resp_at) ? (resp_id ? 2'b10 : 2'b01) : 2'b00;
        e_err   = (r && cyc == err_at) ? (err_id ? 2'b10 : 2'b01) : 2'b00;
        chk("req_ready", 16'(ifc.req_ready), 16'(e_ready));
        chk("busy", 16'(ifc.busy), 16'(e_busy));
        chk("fpu_in_valid", 16'(ifc.fpu_in_valid), 16'(e_iv));
        chk("fpu_mode", 16'(ifc.fpu_mode), 16'(e_iv & iss_mode));
        chk("fpu_a", ifc.fpu_a, e_iv ? iss_a : 16'h0);
        chk("fpu_b", ifc.fpu_b, e_iv ? iss_b : 16'h0);
        chk("resp_valid", 16'(ifc.resp_valid), 16'(e_resp));
        chk("err", 16'(ifc.err), 16'(e_err));
        if (r) chk("resp_data", ifc.resp_data, exp_data);
        if (!r) begin
            lg = 1'b1; free_at = cyc + 1; issue_at = -1; resp_at = -1; err_at = -1; exp_data = '0;
        end else begin
            if (!idle && cyc > issue_at && sp) begin
                resp_at = cyc + 1; resp_id = cur_id; pend_data = spd; err_at = -1; free_at = cyc + 1;
            end
            if (idle && v != 2'b00) begin
                lg = g; cur_id = g; issue_at = cyc + 1;
                iss_mode = m[g]; iss_a = g ? a1 : a0; iss_b = g ? b1 : b0;
                if (!stall) begin
                    resp_at = cyc + 4; resp_id = g; free_at = cyc + 4;
                    pend_data = fpu_op(iss_mode, iss_a, iss_b);
                end else begin
                    err_at = cyc + 6; err_id = g; free_at = cyc + 6;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 2'b00, 2'b00, '0, '0, '0, '0, 1'b0, '0);
    endtask

    task automatic req(input logic [1:0] v, input logic [1:0] m,
                       input logic [15:0] a0, input logic [15:0] b0,
                       input logic [15:0] a1, input logic [15:0] b1);
        step(1'b1, v, m, a0, b0, a1, b1, 1'b0, '0);
    endtask

    initial begin : main
        logic [15:0] held, sd;
        logic        r, sp, idle;
        @(negedge clk);

        // Reset with both requesters already asserting.
        for (int i = 0; i < 3; i++) step(1'b0, 2'b11, 2'b00, rnd_bf(), rnd_bf(), rnd_bf(), rnd_bf(), 1'b0, '0);

        // Contention held from reset: grants alternate 0,1,0,1 every 4 cycles.
        for (int i = 0; i < 16; i++) req(2'b11, 2'(i), rnd_bf(), rnd_bf(), rnd_bf(), rnd_bf());
        idle_n(2);

        // Single add from requester 0.
        req(2'b01, 2'b00, 16'h3F80, 16'h4000, '0, '0);
        chk("add_issue", 16'(ifc.fpu_in_valid), 16'h1);
        idle_n(3);
        chk("add_resp_valid", 16'(ifc.resp_valid), 16'h1);
        chk("add_resp_data", ifc.resp_data, 16'h4040);
        idle_n(1);
        chk("add_pulse_end", 16'(ifc.resp_valid), 16'h0);

        // Single multiply from requester 1.
        req(2'b10, 2'b10, '0, '0, 16'h4000, 16'hC040);
        idle_n(3);
        chk("mul_resp_valid", 16'(ifc.resp_valid), 16'h2);
        chk("mul_resp_data", ifc.resp_data, 16'hC0C0);
        idle_n(1);

        // Timeout: the unit never answers.
        stall = 1'b1;
        req(2'b01, 2'b00, rnd_bf(), rnd_bf(), '0, '0);
        idle_n(5);
        chk("to_err", 16'(ifc.err), 16'h1);
        chk("to_busy", 16'(ifc.busy), 16'h0);
        chk("to_resp_data", ifc.resp_data, 16'hC0C0);
        stall = 1'b0;
        req(2'b10, 2'b01, '0, '0, rnd_bf(), rnd_bf());
        idle_n(4);

        // Reset while waiting; the late result must be ignored and requester 0 wins.
        req(2'b01, 2'b00, rnd_bf(), rnd_bf(), '0, '0);
        idle_n(1);
        step(1'b0, 2'b00, 2'b00, '0, '0, '0, '0, 1'b0, '0);
        chk("rstw_busy", 16'(ifc.busy), 16'h0);
        req(2'b11, 2'b00, rnd_bf(), rnd_bf(), rnd_bf(), rnd_bf());
        chk("rstw_resp_data", ifc.resp_data, 16'h0);
        idle_n(4);

        // Spurious result while idle.
        held = ifc.resp_data;
        step(1'b1, 2'b00, 2'b00, '0, '0, '0, '0, 1'b1, 16'h1234);
        idle_n(1);
        chk("spur_resp_valid", 16'(ifc.resp_valid), 16'h0);
        chk("spur_resp_data", ifc.resp_data, held);

        // Result arriving on the timeout cycle beats the error.
        stall = 1'b1;
        req(2'b10, 2'b01, '0, '0, rnd_bf(), rnd_bf());
        idle_n(4);
        sd = rnd_bf();
        step(1'b1, 2'b00, 2'b00, '0, '0, '0, '0, 1'b1, sd);
        chk("tie_resp_valid", 16'(ifc.resp_valid), 16'h2);
        chk("tie_err", 16'(ifc.err), 16'h0);
        chk("tie_resp_data", ifc.resp_data, sd);
        stall = 1'b0;
        idle_n(1);

        // Random traffic, stalls, spurious pulses and occasional resets.
        for (int i = 0; i < 400; i++) begin
            idle = (cyc >= free_at);
            if (idle) stall = ($urandom_range(0, 5) == 0);
            r  = ($urandom_range(0, 59) != 0);
            sp = (idle || (stall && cyc > issue_at)) && ($urandom_range(0, 7) == 0);
            step(r, 2'($urandom), 2'($urandom), rnd_bf(), rnd_bf(), rnd_bf(), rnd_bf(), sp, rnd_bf());
        end
        stall = 1'b0;
        idle_n(8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fpc_sched.md
FPC_SCHED -- requirements
Module: fpc_sched

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL provide parameter TIMEOUT, default 4: the maximum number of WAIT cycles allowed for fpu_out_valid before an error is raised; legal range 3..15.

Ports (name  direction  width  meaning):
REQ-002 The block SHALL provide clk  input  1  as the single clock; all state changes on its rising edge.
REQ-003 The block SHALL provide rst_n  input  1  as a synchronous, active-low reset.
REQ-004 The block SHALL provide req_valid  input  2  as the per-requester operation-valid signal (bit i = requester i).
REQ-005 The block SHALL provide req_mode  input  2  as the per-requester opcode: 0 = add, 1 = multiply.
REQ-006 The block SHALL provide req_a0, req_b0, req_a1, req_b1  input  16 each  as the bfloat16 operands of requesters 0 and 1.
REQ-007 The block SHALL provide req_ready  output  2  as the per-requester accept signal; a handshake occurs when valid and ready are both high.
REQ-008 The block SHALL provide fpu_in_valid  output  1,  fpu_mode  output  1,  fpu_a  output  16  and  fpu_b  output  16  as the drive to the shared bfloat16 add/mul unit.
REQ-009 The block SHALL provide fpu_out_valid  input  1  and  fpu_out  input  16  as the result from the shared unit.
REQ-010 The block SHALL provide resp_valid  output  2,  resp_data  output  16  and  err  output  2  as per-requester result and timeout-error pulses.
REQ-011 The block SHALL provide busy  output  1, high whenever the state is not IDLE.

Function
REQ-012 The FSM SHALL have states IDLE, ISSUE and WAIT.
- IDLE->ISSUE on a handshake.
- ISSUE->WAIT unconditionally.
- WAIT->IDLE on fpu_out_valid or on timeout.
REQ-013 In IDLE, req_ready SHALL be driven combinationally one-hot to the granted requester when any req_valid is high; req_ready SHALL be 0 in ISSUE and WAIT.
REQ-014 Arbitration SHALL be round-robin.
- With exactly one req_valid high, that requester is granted.
- With both high, the requester other than last_grant is granted.
- last_grant updates only on a handshake.
REQ-015 On a handshake, the mode, operands and requester id SHALL be captured into internal registers.
REQ-016 In ISSUE, fpu_in_valid SHALL be 1 for exactly one cycle, with fpu_mode, fpu_a and fpu_b taken from the captured registers.
REQ-017 In all other states, fpu_in_valid, fpu_mode, fpu_a and fpu_b SHALL be 0.
REQ-018 The shared unit returns fpu_out_valid 2 cycles after the fpu_in_valid cycle and accepts nothing until then; the block SHALL therefore never issue while in WAIT.
REQ-019 In WAIT, a 4-bit counter SHALL increment each cycle starting from 1; if the counter reaches TIMEOUT without fpu_out_valid, the block SHALL leave WAIT.
REQ-020 On fpu_out_valid in WAIT, the block SHALL register fpu_out into resp_data and pulse resp_valid[id] for exactly 1 cycle, in the cycle after fpu_out_valid.
REQ-021 resp_data SHALL hold its value until the next response; resp_valid pulses SHALL be one-hot.
REQ-022 On timeout, the block SHALL pulse err[id] for 1 cycle in the cycle after the timeout, with no resp_valid and resp_data unchanged.
REQ-023 The block SHALL ignore fpu_out_valid in IDLE and ISSUE.
REQ-024 If fpu_out_valid and timeout coincide in the same cycle, the result SHALL take priority and no err is raised.
REQ-025 Handshake-to-resp_valid latency SHALL be 4 cycles.
- Handshake in cycle T; issue in T+1; fpu_out_valid in T+3; resp_valid in T+4.
- A new handshake is possible in T+4, giving a minimum 4-cycle spacing between accepts.
REQ-026 A requester holding req_valid without handshake SHALL not lose its turn; a new handshake in the same cycle as a resp_valid pulse SHALL be legal.

Reset
REQ-027 While rst_n is low at a rising clk edge, the FSM SHALL go to IDLE, last_grant to 1 (requester 0 wins first contention), the WAIT counter to 0, and resp_data to 0x0000.
REQ-028 During reset, req_ready, resp_valid, err, fpu_in_valid, fpu_mode, fpu_a, fpu_b and busy SHALL all be 0.
REQ-029 Reset asserted mid-operation (ISSUE or WAIT) SHALL abandon the operation with no resp_valid and no err.
REQ-030 Reset SHALL ignore any fpu_out_valid arriving in the cycle after reset is released, per REQ-023.

Verification
REQ-031 The bench SHALL cover a single add: req 0 sends mode 0, a=0x3F80 (1.0), b=0x4000 (2.0) in cycle T -> fpu_in_valid in T+1, resp_valid=2'b01 in T+4, resp_data=0x4040 (3.0).
REQ-032 The bench SHALL cover a single multiply: req 1 sends mode 1, a=0x4000, b=0xC040 (-3.0) -> resp_valid=2'b10 in T+4, resp_data=0xC0C0 (-6.0).
REQ-033 The bench SHALL cover contention: both req_valid held high from reset -> grants 0,1,0,1 at accepts 4 cycles apart; each response is routed to the correct requester.
REQ-034 The bench SHALL cover timeout: a stub unit never asserts fpu_out_valid, TIMEOUT=4 -> err[id] pulses 1 cycle after the 4th WAIT cycle, busy drops, and the next request is accepted.
REQ-035 The bench SHALL cover reset in WAIT: rst_n low for 1 cycle in T+2 -> no resp_valid or err; state IDLE; the first later contention grants requester 0.
REQ-036 The bench SHALL cover a spurious result: fpu_out_valid pulsed in IDLE -> no resp_valid and resp_data unchanged.
